// File: rtl/dram_rr_scheduler.sv
// Round-robin scheduler sharing one DRAM controller port among NCORES cores, with AMO lock.
// Define DRAM_WATCHDOG_EN to bound the WAIT state and add the sticky wdog_err output.
module dram_rr_scheduler #(
  parameter int NCORES  = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int QUANTUM = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES-1:0]    lock,
  input  logic [NCORES-1:0]    we,
  input  logic [NCORES*AW-1:0] addr,
  input  logic [NCORES*DW-1:0] wdata,
  output logic [NCORES-1:0]    ack,
  output logic [DW-1:0]        rdata,
  output logic [NCORES-1:0]    grant,
  output logic [AW-1:0]        dram_addr,
  output logic [DW-1:0]        dram_wdata,
  output logic                 dram_we,
  output logic                 dram_le,
  input  logic                 dram_busy,
  input  logic [DW-1:0]        dram_odata
`ifdef DRAM_WATCHDOG_EN
  ,
  output logic                 wdog_err
`endif
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [7:0] QLIM = 8'(QUANTUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   last_r;
  logic [IW-1:0]   owner_r;
  logic [7:0]      qcnt_r;
  logic            locked_r;
  logic            lock_lat_r;
  logic            first_r;
  logic            sel_valid_s;
  logic            hit_s;
  logic [IW-1:0]   sel_idx_s;
  logic [IW-1:0]   cand_s;
`ifdef DRAM_WATCHDOG_EN
  logic [7:0]      wdog_cnt_r;
`endif

  function automatic logic [NCORES-1:0] onehot(input logic [IW-1:0] idx);
    logic [NCORES-1:0] v;
    v = {NCORES{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Next-owner selection: a locked owner with req wins, else first requester after last
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = {IW{1'b0}};
    cand_s      = {IW{1'b0}};
    hit_s       = 1'b0;
    if (locked_r && req[owner_r]) begin
      sel_valid_s = 1'b1;
      sel_idx_s   = owner_r;
    end else begin
      for (int k = 1; k <= NCORES; k++) begin
        cand_s      = IW'((int'(last_r) + k) % NCORES);
        hit_s       = !sel_valid_s && req[cand_s];
        sel_idx_s   = hit_s ? cand_s : sel_idx_s;
        sel_valid_s = sel_valid_s | hit_s;
      end
    end
  end

  // Access FSM IDLE->ISSUE->WAIT->DONE with all outputs registered
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      ack        <= {NCORES{1'b0}};
      rdata      <= {DW{1'b0}};
      grant      <= {NCORES{1'b0}};
      dram_addr  <= {AW{1'b0}};
      dram_wdata <= {DW{1'b0}};
      dram_we    <= 1'b0;
      dram_le    <= 1'b0;
      last_r     <= IW'(NCORES - 1);
      owner_r    <= {IW{1'b0}};
      qcnt_r     <= 8'd0;
      locked_r   <= 1'b0;
      lock_lat_r <= 1'b0;
      first_r    <= 1'b0;
`ifdef DRAM_WATCHDOG_EN
      wdog_cnt_r <= 8'd0;
      wdog_err   <= 1'b0;
`endif
    end else begin
      ack     <= {NCORES{1'b0}};
      dram_le <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // a lock is only honoured while its owner keeps requesting
          if (locked_r && !req[owner_r]) begin
            locked_r <= 1'b0;
            qcnt_r   <= 8'd0;
          end
          if (sel_valid_s) begin
            grant      <= onehot(sel_idx_s);
            owner_r    <= sel_idx_s;
            dram_addr  <= addr[int'(sel_idx_s)*AW +: AW];
            dram_wdata <= wdata[int'(sel_idx_s)*DW +: DW];
            dram_we    <= we[sel_idx_s];
            lock_lat_r <= lock[sel_idx_s];
            dram_le    <= 1'b1;
            state_r    <= ST_ISSUE;
          end else begin
            grant <= {NCORES{1'b0}};
          end
        end
        ST_ISSUE: begin
          first_r <= 1'b1;
`ifdef DRAM_WATCHDOG_EN
          wdog_cnt_r <= 8'd0;
`endif
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // first WAIT cycle is skipped: busy may not have risen yet
          first_r <= 1'b0;
`ifdef DRAM_WATCHDOG_EN
          wdog_cnt_r <= wdog_cnt_r + 8'd1;
          if (!first_r && !dram_busy) begin
            ack     <= onehot(owner_r);
            rdata   <= dram_we ? {DW{1'b0}} : dram_odata;
            state_r <= ST_DONE;
          end else if (dram_busy && (wdog_cnt_r == 8'd254)) begin
            ack      <= onehot(owner_r);
            rdata    <= DW'(32'hDEAD_BEEF);
            wdog_err <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            state_r <= ST_WAIT;
          end
`else
          if (!first_r && !dram_busy) begin
            ack     <= onehot(owner_r);
            rdata   <= dram_we ? {DW{1'b0}} : dram_odata;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_WAIT;
          end
`endif
        end
        ST_DONE: begin
          last_r <= owner_r;
          // lock is taken from the access just completed, bounded by the quantum
          if (lock_lat_r && (qcnt_r < QLIM)) begin
            locked_r <= 1'b1;
            qcnt_r   <= qcnt_r + 8'd1;
          end else begin
            locked_r <= 1'b0;
            qcnt_r   <= 8'd0;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
